// File: rtl/sata_fis_capture_if.sv
// Frame-in / captured-FIS-out bundle for sata_fis_capture.
// The master modport belongs to the frame source and consumer; the slave modport belongs to the capture block.
interface sata_fis_capture_if #(
  parameter int unsigned FIS_LEN = 5
);
  logic [31:0]           i_dat;
  logic                  i_val;
  logic                  i_eop;
  logic                  i_err;
  logic                  i_rdy;
  logic [FIS_LEN*32-1:0] o_fis;
  logic [7:0]            o_len;
  logic                  o_badcrc;
  logic                  o_short;
  logic                  o_long;
  logic                  o_val;
  logic                  o_ovf;

  modport master (
    output i_dat, i_val, i_eop, i_err, i_rdy,
    input  o_fis, o_len, o_badcrc, o_short, o_long, o_val, o_ovf
  );

  modport slave (
    input  i_dat, i_val, i_eop, i_err, i_rdy,
    output o_fis, o_len, o_badcrc, o_short, o_long, o_val, o_ovf
  );
endinterface

// File: rtl/sata_fis_capture.sv
// Captures a word-serial SATA FIS into an accumulator and hands completed frames,
// with length and CRC/size flags, to a double-buffered output register set.
module sata_fis_capture #(
  parameter int unsigned FIS_LEN   = 5,
  parameter int unsigned MIN_LEN   = 1,
  parameter int unsigned ZERO_FILL = 1
) (
  input  logic              clk,
  input  logic              reset,
  sata_fis_capture_if.slave bus
);
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned FIS_W   = FIS_LEN * WORD_W;
  localparam logic [7:0]  FIS_LEN8 = 8'(FIS_LEN);
  localparam logic [7:0]  MIN_LEN8 = 8'(MIN_LEN);
  localparam logic [7:0]  CNT_MAX  = 8'hFF;

  logic [7:0]        cnt;
  logic [WORD_W-1:0] acc [FIS_LEN];
  logic [FIS_W-1:0]  fis_q;
  logic [7:0]        len_q;
  logic              badcrc_q;
  logic              short_q;
  logic              long_q;
  logic              val_q;
  logic              ovf_q;

  logic [WORD_W-1:0] acc_nxt [FIS_LEN];
  logic [FIS_W-1:0]  fis_nxt;
  logic [7:0]        len_nxt;
  logic              complete_c;
  logic              take_c;
  logic              drop_c;

  // Next accumulator contents including the current beat, so a completing
  // beat is visible in the frame handed to the output registers.
  always_comb begin
    for (int k = 0; k < int'(FIS_LEN); k++) begin
      acc_nxt[k] = acc[k];
    end
    if (bus.i_val) begin
      if ((ZERO_FILL != 0) && (cnt == 8'd0)) begin
        for (int k = 0; k < int'(FIS_LEN); k++) begin
          acc_nxt[k] = '0;
        end
      end
      for (int k = 0; k < int'(FIS_LEN); k++) begin
        if (cnt == 8'(k)) begin
          acc_nxt[k] = bus.i_dat;
        end
      end
    end
    fis_nxt = '0;
    for (int k = 0; k < int'(FIS_LEN); k++) begin
      fis_nxt[k*WORD_W +: WORD_W] = acc_nxt[k];
    end
  end

  always_comb begin
    len_nxt    = (cnt == CNT_MAX) ? CNT_MAX : (cnt + 8'd1);
    complete_c = bus.i_val & bus.i_eop;
    // A pending frame frees its slot in the same cycle it is consumed.
    take_c     = complete_c & (~val_q | bus.i_rdy);
    drop_c     = complete_c & val_q & ~bus.i_rdy;
  end

  // Word index counter and accumulator.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= 8'd0;
      for (int k = 0; k < int'(FIS_LEN); k++) begin
        acc[k] <= '0;
      end
    end else if (bus.i_val) begin
      cnt <= bus.i_eop ? 8'd0 : len_nxt;
      for (int k = 0; k < int'(FIS_LEN); k++) begin
        acc[k] <= acc_nxt[k];
      end
    end
  end

  // Output frame registers and handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fis_q    <= '0;
      len_q    <= 8'd0;
      badcrc_q <= 1'b0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      val_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      ovf_q <= drop_c;
      if (take_c) begin
        fis_q    <= fis_nxt;
        len_q    <= len_nxt;
        badcrc_q <= bus.i_err;
        short_q  <= (len_nxt < MIN_LEN8);
        long_q   <= (len_nxt > FIS_LEN8);
        val_q    <= 1'b1;
      end else if (val_q && bus.i_rdy) begin
        val_q <= 1'b0;
      end
    end
  end

  assign bus.o_fis    = fis_q;
  assign bus.o_len    = len_q;
  assign bus.o_badcrc = badcrc_q;
  assign bus.o_short  = short_q;
  assign bus.o_long   = long_q;
  assign bus.o_val    = val_q;
  assign bus.o_ovf    = ovf_q;
endmodule

// File: doc/sata_fis_capture.md
SATA_FIS_CAPTURE -- requirements
Module: sata_fis_capture

Interface
REQ-001 Parameter FIS_LEN, default 5, range 1..16 -- number of 32-bit FIS words captured per frame.
REQ-002 Parameter MIN_LEN, default 1, range 1..FIS_LEN -- minimum legal frame length in words.
REQ-003 Parameter ZERO_FILL, default 1 -- 1: words not received in a frame read as zero; 0: they hold the previous frame's content.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 clk  in  1  single clock; all logic rises on clk.
REQ-006 i_dat  in  32  frame data word, word 0 first.
REQ-007 i_val  in  1  i_dat is valid this cycle.
REQ-008 i_eop  in  1  last word of the frame; qualified by i_val.
REQ-009 i_err  in  1  CRC error flag; sampled only on the i_val & i_eop beat.
REQ-010 o_fis  out  FIS_LEN*32  captured frame; word k at bits [32k+31:32k].
REQ-011 o_len  out  8  words received in the frame, saturating at 255.
REQ-012 o_badcrc  out  1  i_err was set on the frame's eop beat.
REQ-013 o_short  out  1  o_len < MIN_LEN.
REQ-014 o_long  out  1  o_len > FIS_LEN; words beyond FIS_LEN were discarded.
REQ-015 o_val  out  1  o_fis, o_len and the flags hold a complete frame.
REQ-016 i_rdy  in  1  consumer accepts the frame when o_val & i_rdy.
REQ-017 o_ovf  out  1  one-cycle pulse: a completed frame was dropped.

Function
REQ-018 The block SHALL hold a word index counter, 0 at frame start, incremented on each i_val beat and saturating at 255.
REQ-019 Each i_val beat with index < FIS_LEN SHALL write i_dat into accumulator word [index]; beats with index >= FIS_LEN SHALL only advance the counter.
REQ-020 With ZERO_FILL=1, every accumulator word SHALL be cleared on the first beat of a frame, except word 0, which takes i_dat.
REQ-021 On an i_val & i_eop beat the frame SHALL complete: length = index+1 (saturated), and the counter SHALL return to 0.
REQ-022 A single-beat frame (i_eop on the first beat) SHALL complete with length 1.
REQ-023 Completed frames SHALL be transferred to separate output registers, so capture of the next frame never disturbs o_fis while o_val=1.
REQ-024 Latency: o_val and all output fields SHALL update on the clk edge after the eop beat.
REQ-025 The flags SHALL be computed from the completed frame: o_badcrc=i_err on the eop beat; o_short=(len<MIN_LEN); o_long=(len>FIS_LEN).
REQ-026 o_val SHALL be set on transfer, stay 1 and keep all fields stable until a cycle with o_val & i_rdy, then clear on the next edge.
REQ-027 If a frame completes while o_val=1 and i_rdy=0, the new frame SHALL be discarded, the outputs SHALL keep the old frame, and o_ovf SHALL pulse high for one cycle after the eop beat.
REQ-028 If a frame completes in the same cycle as o_val & i_rdy, the new frame SHALL be transferred, o_val SHALL stay 1, and o_ovf SHALL stay 0.
REQ-029 Cycles with i_val=0 SHALL change no state except o_val clearing by handshake and o_ovf returning to 0.
REQ-030 i_eop and i_err SHALL be ignored when i_val=0; i_err SHALL be ignored on non-eop beats.

Reset
REQ-031 While reset=1: o_fis=0, o_len=0, o_badcrc=0, o_short=0, o_long=0, o_val=0, o_ovf=0; accumulator=0; counter=0.
REQ-032 Reset asserted mid-frame SHALL discard the partial frame; the first i_val after release SHALL be word 0.
REQ-033 Reset asserted while o_val=1 SHALL drop the pending frame without an o_ovf pulse.

Verification
REQ-034 FIS_LEN=5, 5-beat frame 0x11..0x55, i_err=0, i_rdy=1 -> one cycle after eop: o_val=1, o_fis words 0x11..0x55, o_len=5, all flags 0.
REQ-035 FIS_LEN=5, MIN_LEN=2, 1-beat frame 0xA7 with i_err=1 -> o_fis word0=0xA7, words1..4=0, o_len=1, o_short=1, o_badcrc=1.
REQ-036 FIS_LEN=5, 7-beat frame -> o_len=7, o_long=1, words 0..4 = beats 0..4; then a 3-beat frame with ZERO_FILL=1 -> words 3..4=0.
REQ-037 i_rdy=0, frame A completes, then frame B completes -> o_ovf pulses once, o_fis still holds A; with i_rdy=1 -> o_val clears on the next edge.
REQ-038 Frame B's eop in the same cycle as o_val & i_rdy for frame A -> o_val stays 1 with B's content, o_ovf=0.
REQ-039 Reset on beat 3 of a 5-beat frame, then a clean 2-beat frame -> o_len=2, data from the new frame only, o_ovf=0.
